// File: rtl/fp32_to_int_conv_pkg.sv
// Shared FP32 types, class codes and integer saturation limits for the float datapath.
// Exponent thresholds for float-to-int conversion are derived from the bias.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_SUBNORM,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_e;

    localparam int FP32_BIAS    = 127;
    localparam int FP32_EXP_MAX = 255;

    localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
    localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;

    // Exponent where the mantissa LSB has weight 1, where the MSB is the 0.5 bit,
    // and where the value first exceeds the int32 / uint32 range.
    localparam logic [7:0] EXP_INT_LSB = 8'(FP32_BIAS + 23);
    localparam logic [7:0] EXP_HALF    = 8'(FP32_BIAS - 1);
    localparam logic [7:0] EXP_S_OVF   = 8'(FP32_BIAS + 31);
    localparam logic [7:0] EXP_U_OVF   = 8'(FP32_BIAS + 32);

endpackage

// File: rtl/fp32_to_int_conv_if.sv
// Valid/ready stream bundle for the FP32-to-integer converter (operand in, result out).
// c_flags {invalid, inexact} exists only when FP2I_FLAGS_EN is defined.
interface fp32_to_int_conv_if;
    logic [31:0] a;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] c;
    logic        c_valid;
    logic        c_ready;
`ifdef FP2I_FLAGS_EN
    logic [1:0]  c_flags;

    modport slave  (input  a, a_valid, c_ready, output a_ready, c, c_valid, c_flags);
    modport master (output a, a_valid, c_ready, input  a_ready, c, c_valid, c_flags);
`else
    modport slave  (input  a, a_valid, c_ready, output a_ready, c, c_valid);
    modport master (output a, a_valid, c_ready, input  a_ready, c, c_valid);
`endif
endinterface

// File: rtl/fp32_to_int_conv_classify.sv
// Combinational FP32 unpack and class decode (shared with the adder special-case path).
// Latency: none. Backpressure: none, pure logic.
module fp32_classify
    import fp_pkg::*;
(
    input  fp32_t       a_i,
    output fp_class_e   cls_o,
    output logic        sign_o,
    output logic [23:0] mant_o
);

    always_comb begin
        sign_o = a_i.sign;
        mant_o = {a_i.exp != 8'd0, a_i.frac};
        cls_o  = FP_NORMAL;
        if (a_i.exp == 8'(FP32_EXP_MAX)) begin
            cls_o = (a_i.frac != 23'd0) ? FP_NAN : FP_INF;
        end else if (a_i.exp == 8'd0) begin
            cls_o = (a_i.frac != 23'd0) ? FP_SUBNORM : FP_ZERO;
        end
    end

endmodule

// File: rtl/fp32_to_int_conv.sv
// FP32 -> int32/uint32 converter, RNE with saturation; optional flags via FP2I_FLAGS_EN.
// Latency 3 cycles, one result per cycle; ready propagates combinationally back through stages.
module fp32_to_int_conv
    import fp_pkg::*;
#(
    parameter int SIGNED = 1
) (
    input  logic               clk,
    input  logic               rst,
    fp32_to_int_conv_if.slave  io
);

    fp32_t a_in;
    assign a_in = io.a;

    logic v1_q, v2_q, v3_q;
    logic rdy1, rdy2, rdy3;

    assign rdy3       = !v3_q || io.c_ready;
    assign rdy2       = !v2_q || rdy3;
    assign rdy1       = !v1_q || rdy2;
    assign io.a_ready = rdy1 && !rst;
    assign io.c_valid = v3_q;

    // ---------------- S1: classify and plan the shift ----------------
    fp_class_e   cls1_d, cls1_q;
    logic        sign1_d, sign1_q;
    logic [23:0] mant1_d, mant1_q;
    logic        left1_d, left1_q;
    logic        tiny1_d, tiny1_q;
    logic        ovf1_d, ovf1_q;
    logic [7:0]  amt1_d, amt1_q;

    fp32_classify u_classify (
        .a_i    (a_in),
        .cls_o  (cls1_d),
        .sign_o (sign1_d),
        .mant_o (mant1_d)
    );

    always_comb begin
        left1_d = 1'b0;
        tiny1_d = 1'b0;
        amt1_d  = 8'd0;
        if (a_in.exp >= EXP_INT_LSB) begin
            left1_d = 1'b1;
            amt1_d  = (a_in.exp >= EXP_S_OVF) ? 8'd8 : (a_in.exp - EXP_INT_LSB);
        end else if (a_in.exp >= EXP_HALF) begin
            amt1_d = EXP_INT_LSB - a_in.exp;
        end else begin
            tiny1_d = 1'b1;
        end
        // -2^31 is the only e=158 value representable as int32.
        if (SIGNED != 0) begin
            ovf1_d = (a_in.exp >= EXP_S_OVF) &&
                     !(a_in.sign && (a_in.exp == EXP_S_OVF) && (a_in.frac == 23'd0));
        end else begin
            ovf1_d = (a_in.exp >= EXP_U_OVF);
        end
    end

    // ---------------- S2: barrel shift with guard/sticky ----------------
    fp_class_e   cls2_q;
    logic        sign2_q, ovf2_q;
    logic [31:0] mag2_d, mag2_q;
    logic        grd2_d, grd2_q;
    logic        stk2_d, stk2_q;
    logic [47:0] rsh;
    logic [31:0] lsh;

    always_comb begin
        rsh    = {mant1_q, 24'd0} >> amt1_q;
        lsh    = {8'd0, mant1_q} << amt1_q;
        mag2_d = 32'd0;
        grd2_d = 1'b0;
        stk2_d = 1'b0;
        case (cls1_q)
            FP_SUBNORM: stk2_d = 1'b1;
            FP_NORMAL: begin
                if (tiny1_q) begin
                    stk2_d = 1'b1;
                end else if (left1_q) begin
                    mag2_d = lsh;
                end else begin
                    mag2_d = {8'd0, rsh[47:24]};
                    grd2_d = rsh[23];
                    stk2_d = |rsh[22:0];
                end
            end
            default: ;
        endcase
    end

    // ---------------- S3: round, negate, saturate ----------------
    logic        inc3, is_nan3, sat3;
    logic [31:0] rmag3;
    logic [31:0] c_d, c_q;

    always_comb begin
        inc3    = grd2_q && (stk2_q || mag2_q[0]);
        rmag3   = mag2_q + {31'd0, inc3};
        is_nan3 = (cls2_q == FP_NAN);
        sat3    = is_nan3 || (cls2_q == FP_INF) || ovf2_q;
        if (SIGNED != 0) begin
            if (sat3) begin
                c_d = (is_nan3 || !sign2_q) ? INT32_MAX : INT32_MIN;
            end else begin
                c_d = sign2_q ? (~rmag3 + 32'd1) : rmag3;
            end
        end else begin
            if (is_nan3 || (sat3 && !sign2_q)) begin
                c_d = UINT32_MAX;
            end else if (sign2_q) begin
                c_d = 32'd0;
            end else begin
                c_d = rmag3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            c_q  <= 32'd0;
        end else begin
            if (rdy1) v1_q <= io.a_valid;
            if (rdy2) v2_q <= v1_q;
            if (rdy3) begin
                v3_q <= v2_q;
                if (v2_q) c_q <= c_d;
            end
        end
    end

    // Datapath registers only move on a real load, so they need no reset.
    always_ff @(posedge clk) begin
        if (rdy1 && io.a_valid) begin
            cls1_q  <= cls1_d;
            sign1_q <= sign1_d;
            mant1_q <= mant1_d;
            left1_q <= left1_d;
            tiny1_q <= tiny1_d;
            ovf1_q  <= ovf1_d;
            amt1_q  <= amt1_d;
        end
        if (rdy2 && v1_q) begin
            cls2_q  <= cls1_q;
            sign2_q <= sign1_q;
            ovf2_q  <= ovf1_q;
            mag2_q  <= mag2_d;
            grd2_q  <= grd2_d;
            stk2_q  <= stk2_d;
        end
    end

    assign io.c = c_q;

`ifdef FP2I_FLAGS_EN
    logic       inv3, inx3;
    logic [1:0] flags_q;

    always_comb begin
        if (SIGNED != 0) begin
            inv3 = sat3;
        end else begin
            inv3 = is_nan3 || sat3 || (sign2_q && (rmag3 != 32'd0));
        end
        inx3 = !inv3 && (grd2_q || stk2_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 2'b00;
        end else if (rdy3 && v2_q) begin
            flags_q <= {inv3, inx3};
        end
    end

    assign io.c_flags = flags_q;
`endif

endmodule

// File: tb/tb_fp32_to_int_conv.sv
// Directed bench for fp32_to_int_conv: signed and unsigned instances, hand-computed vectors.
module tb_fp32_to_int_conv;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp32_to_int_conv_if if_s ();
    fp32_to_int_conv_if if_u ();

    fp32_to_int_conv #(.SIGNED(1)) dut_s (.clk(clk), .rst(rst), .io(if_s));
    fp32_to_int_conv #(.SIGNED(0)) dut_u (.clk(clk), .rst(rst), .io(if_u));

    // Sends one operand into an idle pipeline and waits (bounded) for its result.
    task automatic run_one(input bit uns, input logic [31:0] av,
                           output logic [31:0] cv, output logic [1:0] fv, output int lat);
        bit acc;
        cv  = '0;
        fv  = '0;
        lat = 0;
        @(posedge clk); #1;
        if (uns) begin if_u.a = av; if_u.a_valid = 1'b1; if_u.c_ready = 1'b1; end
        else     begin if_s.a = av; if_s.a_valid = 1'b1; if_s.c_ready = 1'b1; end
        #1;
        acc = uns ? if_u.a_ready : if_s.a_ready;
        @(posedge clk); #1;
        if_u.a_valid = 1'b0;
        if_s.a_valid = 1'b0;
        if (acc) begin
            for (int n = 0; n < 20; n++) begin
                if (uns ? if_u.c_valid : if_s.c_valid) begin
                    cv = uns ? if_u.c : if_s.c;
`ifdef FP2I_FLAGS_EN
                    fv = uns ? if_u.c_flags : if_s.c_flags;
`endif
                    lat = n + 1;
                    break;
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_s.a = '0; if_s.a_valid = 1'b0; if_s.c_ready = 1'b0;
        if_u.a = '0; if_u.a_valid = 1'b0; if_u.c_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (if_s.a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready got %b want 0", if_s.a_ready); end
        checks++; if (if_s.c_valid !== 1'b0) begin errors++; $display("FAIL rst_c_valid got %b want 0", if_s.c_valid); end
        checks++; if (if_s.c !== 32'd0) begin errors++; $display("FAIL rst_c got %h want 00000000", if_s.c); end
        checks++; if (if_u.c_valid !== 1'b0) begin errors++; $display("FAIL rst_u_c_valid got %b want 0", if_u.c_valid); end
`ifdef FP2I_FLAGS_EN
        checks++; if (if_s.c_flags !== 2'b00) begin errors++; $display("FAIL rst_flags got %b want 00", if_s.c_flags); end
`endif
        rst = 1'b0;
        #1;
        checks++; if (if_s.a_ready !== 1'b1) begin errors++; $display("FAIL rel_a_ready got %b want 1", if_s.a_ready); end
        checks++; if (if_u.a_ready !== 1'b1) begin errors++; $display("FAIL rel_u_a_ready got %b want 1", if_u.a_ready); end
    endtask

    task automatic test_signed_vectors();
        logic [31:0] vin  [18];
        logic [31:0] vexp [18];
        logic [1:0]  vfl  [18];
        logic [31:0] cv;
        logic [1:0]  fv;
        int          lat;
        vin  = '{32'h3FC00000, 32'h40200000, 32'hC0600000, 32'h41200000, 32'h4F000000, 32'hCF000000,
                 32'h00000001, 32'h80000000, 32'h7FC00000, 32'hFF800000, 32'h3F000000, 32'h3F400000,
                 32'h4EFFFFFF, 32'hCF000001, 32'h7F800000, 32'h3E800000, 32'hBFC00000, 32'h4B7FFFFF};
        vexp = '{32'h00000002, 32'h00000002, 32'hFFFFFFFC, 32'h0000000A, 32'h7FFFFFFF, 32'h80000000,
                 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000001,
                 32'h7FFFFF80, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'hFFFFFFFE, 32'h00FFFFFF};
        vfl  = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00,
                 2'b01, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01,
                 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
        for (int i = 0; i < 18; i++) begin
            run_one(1'b0, vin[i], cv, fv, lat);
            checks++;
            if (cv !== vexp[i]) begin
                errors++; $display("FAIL s_value[%0d] a=%h got %h want %h", i, vin[i], cv, vexp[i]);
            end
            checks++;
            if (lat !== 3) begin
                errors++; $display("FAIL s_latency[%0d] a=%h got %0d want 3", i, vin[i], lat);
            end
`ifdef FP2I_FLAGS_EN
            checks++;
            if (fv !== vfl[i]) begin
                errors++; $display("FAIL s_flags[%0d] a=%h got %b want %b", i, vin[i], fv, vfl[i]);
            end
`endif
        end
    endtask

    task automatic test_unsigned_vectors();
        logic [31:0] vin  [11];
        logic [31:0] vexp [11];
        logic [1:0]  vfl  [11];
        logic [31:0] cv;
        logic [1:0]  fv;
        int          lat;
        vin  = '{32'hBF000000, 32'hC0000000, 32'h4F800000, 32'h4F000000, 32'h7FC00000, 32'hFF800000,
                 32'h40200000, 32'h80000000, 32'h4F7FFFFF, 32'hBEFFFFFF, 32'h7F800000};
        vexp = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000,
                 32'h00000002, 32'h00000000, 32'hFFFFFF00, 32'h00000000, 32'hFFFFFFFF};
        vfl  = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10,
                 2'b01, 2'b00, 2'b00, 2'b01, 2'b10};
        for (int i = 0; i < 11; i++) begin
            run_one(1'b1, vin[i], cv, fv, lat);
            checks++;
            if (cv !== vexp[i]) begin
                errors++; $display("FAIL u_value[%0d] a=%h got %h want %h", i, vin[i], cv, vexp[i]);
            end
            checks++;
            if (lat !== 3) begin
                errors++; $display("FAIL u_latency[%0d] a=%h got %0d want 3", i, vin[i], lat);
            end
`ifdef FP2I_FLAGS_EN
            checks++;
            if (fv !== vfl[i]) begin
                errors++; $display("FAIL u_flags[%0d] a=%h got %b want %b", i, vin[i], fv, vfl[i]);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] sin  [8];
        logic [31:0] sexp [8];
        bit          pat  [8];
        int          sent = 0, rcvd = 0, inflight = 0, cyc = 0;
        bit          prev_stall = 1'b0, acc, emit, exp_rdy;
        logic [31:0] prev_c = '0;
        sin  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'hBF800000, 32'h42C80000, 32'h3F000000};
        sexp = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'hFFFFFFFF, 32'd100, 32'd0};
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        @(posedge clk); #1;
        while (rcvd < 8 && cyc < 200) begin
            if_s.c_ready = pat[cyc % 8];
            if_s.a_valid = (sent < 8);
            if (sent < 8) if_s.a = sin[sent];
            @(negedge clk);
            exp_rdy = !(inflight == 3 && !if_s.c_ready);
            checks++;
            if (if_s.a_ready !== exp_rdy) begin
                errors++; $display("FAIL bp_a_ready cyc=%0d got %b want %b", cyc, if_s.a_ready, exp_rdy);
            end
            if (prev_stall) begin
                checks++;
                if (if_s.c_valid !== 1'b1 || if_s.c !== prev_c) begin
                    errors++; $display("FAIL bp_stable cyc=%0d got v=%b c=%h want v=1 c=%h",
                                       cyc, if_s.c_valid, if_s.c, prev_c);
                end
            end
            acc  = if_s.a_valid && if_s.a_ready;
            emit = if_s.c_valid && if_s.c_ready;
            if (emit) begin
                checks++;
                if (if_s.c !== sexp[rcvd]) begin
                    errors++; $display("FAIL bp_order[%0d] got %h want %h", rcvd, if_s.c, sexp[rcvd]);
                end
                rcvd++;
            end
            prev_stall = if_s.c_valid && !if_s.c_ready;
            prev_c     = if_s.c;
            if (acc) sent++;
            inflight = inflight + int'(acc) - int'(emit);
            @(posedge clk); #1;
            cyc++;
        end
        if_s.a_valid = 1'b0;
        if_s.c_ready = 1'b1;
        checks++;
        if (rcvd != 8) begin errors++; $display("FAIL bp_count got %0d want 8", rcvd); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] vals [3];
        logic [31:0] cv;
        logic [1:0]  fv;
        int          lat;
        bit          seen = 1'b0;
        vals = '{32'h41000000, 32'h41100000, 32'h41200000};
        @(posedge clk); #1;
        if_s.c_ready = 1'b0;
        if_s.a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_s.a = vals[i];
            @(posedge clk); #1;
        end
        if_s.a_valid = 1'b0;
        checks++;
        if (if_s.c_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight got %b want 1", if_s.c_valid); end
        rst = 1'b1;
        #1;
        checks++;
        if (if_s.a_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_a_ready got %b want 0", if_s.a_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (if_s.c_valid !== 1'b0) begin errors++; $display("FAIL mid_c_valid got %b want 0", if_s.c_valid); end
        #1;
        checks++;
        if (if_s.a_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_a_ready got %b want 1", if_s.a_ready); end
        if_s.c_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (if_s.c_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL mid_stale got c_valid=1 want 0"); end
        run_one(1'b0, 32'h40E00000, cv, fv, lat);
        checks++;
        if (cv !== 32'd7 || lat !== 3) begin
            errors++; $display("FAIL mid_after got c=%h lat=%0d want c=00000007 lat=3", cv, lat);
        end
    endtask

    initial begin
        test_reset();
        test_signed_vectors();
        test_unsigned_vectors();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
